// File: rtl/ysyx_25040129_axi_mem.sv
// AXI responder backed by a word-addressed RAM with independent read and write paths.
// Define AXI_MEM_DELAY_EN to insert DELAY wait cycles before the first R beat and before B.
module ysyx_25040129_axi_mem #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          DELAY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [2:0]  arsize,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
`ifdef AXI_MEM_DELAY_EN
    R_WAIT = 2'd1,
`endif
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
`ifdef AXI_MEM_DELAY_EN
    W_WAIT = 2'd1,
`endif
    W_RESP = 2'd2
  } w_state_e;

  logic [31:0] mem [WORDS];

  r_state_e    r_state;
  logic [31:0] rd_addr;
  logic [31:0] rd_next;
  logic [7:0]  rd_len;
  logic [2:0]  rd_size;
  logic [1:0]  rd_burst;
  logic [7:0]  beat;

  w_state_e    w_state;
  logic        aw_held;
  logic        w_held;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        aw_take;
  logic        w_take;
  logic [31:0] wr_addr_eff;
  logic [31:0] wr_data_eff;
  logic [3:0]  wr_strb_eff;
  logic        wr_go;
  logic        wr_commit;
  logic [DEPTH_LOG2-1:0] wr_idx;

`ifdef AXI_MEM_DELAY_EN
  logic [31:0] r_wait;
  logic [31:0] w_wait;
`else
  // Wait states are compiled out; DELAY is accepted but has no effect in this build.
  if (DELAY < 0) begin : g_delay_unused
  end
`endif

  // Addresses below BASE_ADDR wrap to huge offsets and so fall out of range too.
  function automatic logic in_range(input logic [31:0] a);
    return ((a - BASE_ADDR) >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return in_range(a) ? mem[word_idx(a)] : 32'd0;
  endfunction

  function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [2:0] size,
                                           input logic [1:0] burst);
    if (!in_range(a)) return 2'b11;
    if (size > 3'd2 || burst[1]) return 2'b10;
    return 2'b00;
  endfunction

  assign arready = (r_state == R_IDLE);
  assign rd_next = (rd_burst == 2'b00) ? rd_addr : rd_addr + (32'd1 << rd_size);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= R_IDLE;
      rd_addr  <= 32'd0;
      rd_len   <= 8'd0;
      rd_size  <= 3'd0;
      rd_burst <= 2'd0;
      beat     <= 8'd0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rdata    <= 32'd0;
      rresp    <= 2'b00;
`ifdef AXI_MEM_DELAY_EN
      r_wait   <= 32'd0;
`endif
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rd_addr  <= araddr;
            rd_len   <= arlen;
            rd_size  <= arsize;
            rd_burst <= arburst;
            beat     <= 8'd0;
`ifdef AXI_MEM_DELAY_EN
            r_wait   <= 32'd0;
            r_state  <= R_WAIT;
`else
            rdata    <= word_at(araddr);
            rresp    <= beat_resp(araddr, arsize, arburst);
            rlast    <= (arlen == 8'd0);
            rvalid   <= 1'b1;
            r_state  <= R_DATA;
`endif
          end
        end
`ifdef AXI_MEM_DELAY_EN
        R_WAIT: begin
          if (r_wait == 32'(DELAY - 1)) begin
            rdata   <= word_at(rd_addr);
            rresp   <= beat_resp(rd_addr, rd_size, rd_burst);
            rlast   <= (rd_len == 8'd0);
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
`endif
        R_DATA: begin
          if (rready) begin
            if (beat == rd_len) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              r_state <= R_IDLE;
            end else begin
              rd_addr <= rd_next;
              beat    <= beat + 8'd1;
              rdata   <= word_at(rd_next);
              rresp   <= beat_resp(rd_next, rd_size, rd_burst);
              rlast   <= (beat + 8'd1 == rd_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign awready     = (w_state == W_IDLE) && !aw_held;
  assign wready      = (w_state == W_IDLE) && !w_held;
  assign aw_take     = awvalid && awready;
  assign w_take      = wvalid && wready;
  assign wr_addr_eff = aw_held ? aw_addr : awaddr;
  assign wr_data_eff = w_held ? w_data : wdata;
  assign wr_strb_eff = w_held ? w_strb : wstrb;
  // Commit on the edge where the second of AW/W arrives (or both arrive together).
  assign wr_go       = (aw_held || aw_take) && (w_held || w_take);
  assign wr_commit   = wr_go && in_range(wr_addr_eff);
  assign wr_idx      = word_idx(wr_addr_eff);

  always_ff @(posedge clk) begin
    if (rst && wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_eff[b]) mem[wr_idx][8*b +: 8] <= wr_data_eff[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= 32'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
`ifdef AXI_MEM_DELAY_EN
      w_wait  <= 32'd0;
`endif
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_go) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp   <= in_range(wr_addr_eff) ? 2'b00 : 2'b11;
`ifdef AXI_MEM_DELAY_EN
            w_wait  <= 32'd0;
            w_state <= W_WAIT;
`else
            bvalid  <= 1'b1;
            w_state <= W_RESP;
`endif
          end else begin
            if (aw_take) begin
              aw_held <= 1'b1;
              aw_addr <= awaddr;
            end
            if (w_take) begin
              w_held <= 1'b1;
              w_data <= wdata;
              w_strb <= wstrb;
            end
          end
        end
`ifdef AXI_MEM_DELAY_EN
        W_WAIT: begin
          if (w_wait == 32'(DELAY - 1)) begin
            bvalid  <= 1'b1;
            w_state <= W_RESP;
          end else begin
            w_wait <= w_wait + 32'd1;
          end
        end
`endif
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_axi_mem.sv
// Directed testbench for ysyx_25040129_axi_mem in its default (no wait state) build.
module tb_ysyx_25040129_axi_mem;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = 32'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [2:0]  arsize = 3'd0;
  logic [7:0]  arlen = 8'd0;
  logic [1:0]  arburst = 2'd0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        rlast;
  logic [31:0] awaddr = 32'd0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_data [16];
  logic [1:0]  got_resp [16];
  logic        got_last [16];
  logic        first_valid;

  ysyx_25040129_axi_mem dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick(); n++;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("wr_accepted", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    checkOutput("wr_bvalid", 32'(bvalid), 32'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input bit toggle);
    int n, beats;
    bit prev_stall;
    logic [31:0] hold_d;
    logic [1:0]  hold_r;
    logic        hold_l;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    first_valid = rvalid;
    rready = 1'b0; prev_stall = 0; beats = 0; n = 0;
    hold_d = 32'd0; hold_r = 2'd0; hold_l = 1'b0;
    while (beats <= int'(len) && n < 200) begin
      rready = toggle ? ~rready : 1'b1;
      if (rvalid) begin
        if (prev_stall) begin
          checkOutput("stall_data", rdata, hold_d);
          checkOutput("stall_resp", 32'(rresp), 32'(hold_r));
          checkOutput("stall_last", 32'(rlast), 32'(hold_l));
        end
        if (rready) begin
          got_data[beats] = rdata; got_resp[beats] = rresp; got_last[beats] = rlast;
          beats++; prev_stall = 0;
        end else begin
          prev_stall = 1; hold_d = rdata; hold_r = rresp; hold_l = rlast;
        end
      end
      tick(); n++;
    end
    rready = 1'b0;
    checkOutput("rd_beats", 32'(beats), 32'(len) + 32'd1);
  endtask

  initial begin
    logic [1:0] resp;

    rst = 1'b0;
    tick(); tick();
    checkOutput("rst_arready", 32'(arready), 32'd1);
    checkOutput("rst_awready", 32'(awready), 32'd1);
    checkOutput("rst_wready",  32'(wready),  32'd1);
    checkOutput("rst_rvalid",  32'(rvalid),  32'd0);
    checkOutput("rst_rlast",   32'(rlast),   32'd0);
    checkOutput("rst_rdata",   rdata,        32'd0);
    checkOutput("rst_rresp",   32'(rresp),   32'd0);
    checkOutput("rst_bvalid",  32'(bvalid),  32'd0);
    checkOutput("rst_bresp",   32'(bresp),   32'd0);
    rst = 1'b1;
    tick();

    // Preload through the write channel: full-strobe writes
    axiWrite(BASE + 32'd0,  32'h1234_5678, 4'hF, resp); checkOutput("pre_w0", 32'(resp), 32'd0);
    axiWrite(BASE + 32'd4,  32'hFFFF_FFFF, 4'hF, resp); checkOutput("pre_w1", 32'(resp), 32'd0);
    axiWrite(BASE + 32'd8,  32'h2222_2222, 4'hF, resp); checkOutput("pre_w2", 32'(resp), 32'd0);
    axiWrite(BASE + 32'd12, 32'h3030_3030, 4'hF, resp); checkOutput("pre_w3", 32'(resp), 32'd0);
    for (int k = 4; k < 8; k++) begin
      axiWrite(BASE + 32'(4 * k), 32'hA5A5_0000 + 32'(k), 4'hF, resp);
      checkOutput("pre_wa", 32'(resp), 32'd0);
    end
    for (int k = 8; k < 16; k++) begin
      axiWrite(BASE + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 4'hF, resp);
      checkOutput("pre_wc", 32'(resp), 32'd0);
    end
    axiWrite(BASE + 32'h0FFC, 32'h5555_AAAA, 4'hF, resp); checkOutput("pre_wlast", 32'(resp), 32'd0);

    $display("[TB] single beat read");
    axiRead(BASE, 8'd0, 3'd2, 2'b01, 1'b0);
    checkOutput("single_latency", 32'(first_valid), 32'd1);
    checkOutput("single_data", got_data[0], 32'h1234_5678);
    checkOutput("single_resp", 32'(got_resp[0]), 32'd0);
    checkOutput("single_last", 32'(got_last[0]), 32'd1);
    checkOutput("single_done_rvalid", 32'(rvalid), 32'd0);
    checkOutput("single_done_arready", 32'(arready), 32'd1);

    $display("[TB] INCR burst with rready toggling");
    axiRead(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("incr_data", got_data[k], 32'hA5A5_0004 + 32'(k));
      checkOutput("incr_resp", 32'(got_resp[k]), 32'd0);
      checkOutput("incr_last", 32'(got_last[k]), 32'(k == 3));
    end

    $display("[TB] FIXED burst");
    axiRead(BASE + 32'h10, 8'd2, 3'd2, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("fixed_data", got_data[k], 32'hA5A5_0004);
      checkOutput("fixed_last", 32'(got_last[k]), 32'(k == 2));
    end

    $display("[TB] SLVERR cases");
    axiRead(BASE + 32'h10, 8'd1, 3'd3, 2'b01, 1'b0);
    checkOutput("size_err_resp0", 32'(got_resp[0]), 32'd2);
    checkOutput("size_err_resp1", 32'(got_resp[1]), 32'd2);
    checkOutput("size_err_last", 32'(got_last[1]), 32'd1);
    axiRead(BASE + 32'h14, 8'd1, 3'd2, 2'b10, 1'b0);
    checkOutput("wrap_err_resp0", 32'(got_resp[0]), 32'd2);
    checkOutput("wrap_err_resp1", 32'(got_resp[1]), 32'd2);

    $display("[TB] burst crossing the top of memory");
    axiRead(BASE + 32'h0FFC, 8'd1, 3'd2, 2'b01, 1'b0);
    checkOutput("top_data0", got_data[0], 32'h5555_AAAA);
    checkOutput("top_resp0", 32'(got_resp[0]), 32'd0);
    checkOutput("top_data1", got_data[1], 32'd0);
    checkOutput("top_resp1", 32'(got_resp[1]), 32'd3);
    checkOutput("top_last1", 32'(got_last[1]), 32'd1);

    $display("[TB] W two cycles ahead of AW, partial strobe");
    wdata = 32'hAABB_CCDD; wstrb = 4'b0011; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checkOutput("wfirst_wready", 32'(wready), 32'd0);
    checkOutput("wfirst_awready", 32'(awready), 32'd1);
    checkOutput("wfirst_bvalid", 32'(bvalid), 32'd0);
    tick();
    awaddr = BASE + 32'd4; awvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0;
    checkOutput("wfirst_b_valid", 32'(bvalid), 32'd1);
    checkOutput("wfirst_b_resp", 32'(bresp), 32'd0);
    tick();
    bready = 1'b0;
    checkOutput("wfirst_b_done", 32'(bvalid), 32'd0);
    axiRead(BASE + 32'd4, 8'd0, 3'd2, 2'b01, 1'b0);
    checkOutput("wfirst_readback", got_data[0], 32'hFFFF_CCDD);

    $display("[TB] out of range read and write together");
    fork
      axiRead(32'h0000_0000, 8'd0, 3'd2, 2'b01, 1'b0);
      axiWrite(32'h9000_0000, 32'hDEAD_BEEF, 4'hF, resp);
    join
    checkOutput("oor_rresp", 32'(got_resp[0]), 32'd3);
    checkOutput("oor_rdata", got_data[0], 32'd0);
    checkOutput("oor_bresp", 32'(resp), 32'd3);
    axiRead(BASE, 8'd0, 3'd2, 2'b01, 1'b0);
    checkOutput("oor_word0_kept", got_data[0], 32'h1234_5678);

    $display("[TB] read capture and write commit on the same edge");
    fork
      axiRead(BASE + 32'd8, 8'd0, 3'd2, 2'b01, 1'b0);
      axiWrite(BASE + 32'd8, 32'h3333_3333, 4'hF, resp);
    join
    checkOutput("same_edge_old", got_data[0], 32'h2222_2222);
    checkOutput("same_edge_bresp", 32'(resp), 32'd0);
    axiRead(BASE + 32'd8, 8'd0, 3'd2, 2'b01, 1'b0);
    checkOutput("same_edge_new", got_data[0], 32'h3333_3333);

    $display("[TB] write coinciding with reset");
    awaddr = BASE + 32'd12; awvalid = 1'b1; wdata = 32'hBAD0_BAD0; wstrb = 4'hF; wvalid = 1'b1;
    rst = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    checkOutput("rst_wr_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_wr_awready", 32'(awready), 32'd1);
    checkOutput("rst_wr_wready", 32'(wready), 32'd1);
    axiRead(BASE + 32'd12, 8'd0, 3'd2, 2'b01, 1'b0);
    checkOutput("rst_wr_kept", got_data[0], 32'h3030_3030);

    $display("[TB] reset in the middle of a burst");
    araddr = BASE + 32'h20; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    tick(); tick();
    checkOutput("mid_beat2_data", rdata, 32'hC0DE_000A);
    checkOutput("mid_beat2_valid", 32'(rvalid), 32'd1);
    rst = 1'b0; rready = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("mid_rst_rvalid", 32'(rvalid), 32'd0);
    checkOutput("mid_rst_arready", 32'(arready), 32'd1);
    checkOutput("mid_rst_rlast", 32'(rlast), 32'd0);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checkOutput("mid_rst_no_beat", 32'(rvalid), 32'd0);
    axiRead(BASE + 32'h20, 8'd3, 3'd2, 2'b01, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("post_rst_data", got_data[k], 32'hC0DE_0008 + 32'(k));
      checkOutput("post_rst_last", 32'(got_last[k]), 32'(k == 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
